// File: rtl/vga_frame_arb_if.sv
// vga_frame_arb_if
// Bundles the arbiter's signals so they can be passed as one port.
// Covers the sync-generator inputs, the writer handshake, the single-port
// pixel RAM bus, and the DAC-side pixel outputs.
//   slave  : the arbiter's view. It receives the write requests and the
//            display timing, and drives the RAM bus and the pixel output.
//   master : the surrounding system's view. This covers the writer, the
//            sync generator, the RAM and the DAC.
interface vga_frame_arb_if;
  logic        disp_ready;
  logic [10:0] col;
  logic [10:0] row;
  logic        wr_valid;
  logic        wr_ready;
  logic [18:0] wr_addr;
  logic [15:0] wr_data;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic [2:0]  fifo_level;

  modport slave (
    input  disp_ready, col, row, wr_valid, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_addr, mem_we, mem_wdata, pix_data, pix_valid, fifo_level
  );

  modport master (
    output disp_ready, col, row, wr_valid, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_addr, mem_we, mem_wdata, pix_data, pix_valid, fifo_level
  );
endinterface

// File: rtl/vga_frame_arb.sv
// vga_frame_arb
// Shares one single-port 800x600 RGB565 pixel RAM between two users:
//   - The display scan, which always wins during active video.
//   - A pixel writer.
//
// Build option VGA_ARB_WR_FIFO_EN:
//   defined   - Writes are queued in a 4-deep FIFO. The FIFO drains one entry
//               per blanking cycle, in acceptance order.
//   undefined - There is no buffering. The writer is held off during active
//               video, and each accepted write goes straight to the RAM in
//               the same cycle.
//
// Writes addressed beyond the last pixel (479999) are accepted, then dropped.
module vga_frame_arb (
  input logic            clk,
  input logic            rst_n,
  vga_frame_arb_if.slave bus
);

  localparam logic [18:0] LAST_PIXEL = 19'd479999;

  logic [18:0] disp_addr;
  logic        wr_addr_ok;
  logic        pix_valid_q;
  logic        pix_valid_d;
  logic        mem_we_c;
  logic [18:0] mem_addr_c;
  logic [15:0] mem_wdata_c;

  // Display-side address.
  // The 19-bit product covers 599*800+799 = 479999 exactly.
  always_comb begin
    disp_addr   = ({8'd0, bus.row} * 19'd800) + {8'd0, bus.col};
    wr_addr_ok  = (bus.wr_addr <= LAST_PIXEL);
    pix_valid_d = bus.disp_ready;
  end

  // Delay the active-video flag by one cycle to line up with the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_q <= 1'b0;
    end else begin
      pix_valid_q <= pix_valid_d;
    end
  end

  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_data  = pix_valid_q ? bus.mem_rdata : 16'h0000;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;

`ifdef VGA_ARB_WR_FIFO_EN

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DISP  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [18:0] fifo_addr_q [4];
  logic [18:0] fifo_addr_d [4];
  logic [15:0] fifo_data_q [4];
  logic [15:0] fifo_data_d [4];
  logic [1:0]  rd_ptr_q;
  logic [1:0]  rd_ptr_d;
  logic [1:0]  wr_ptr_q;
  logic [1:0]  wr_ptr_d;
  logic [2:0]  level_q;
  logic [2:0]  level_d;
  logic        wr_ready_q;
  logic        wr_ready_d;
  logic        push;
  logic        pop;

  // FIFO bookkeeping and next state.
  // Display ownership has priority; otherwise stay in DRAIN while anything
  // is still queued once this cycle's push and pop are taken into account.
  always_comb begin
    push        = bus.wr_valid & wr_ready_q & wr_addr_ok;
    pop         = (state_q == DRAIN) & ~bus.disp_ready & (level_q != 3'd0);
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = bus.wr_addr;
      fifo_data_d[wr_ptr_q] = bus.wr_data;
      wr_ptr_d              = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    if (push && !pop) begin
      level_d = level_q + 3'd1;
    end else if (pop && !push) begin
      level_d = level_q - 3'd1;
    end
    wr_ready_d = (level_d < 3'd4);
    if (bus.disp_ready) begin
      state_d = DISP;
    end else if (level_d != 3'd0) begin
      state_d = DRAIN;
    end else begin
      state_d = IDLE;
    end
  end

  // RAM port mux.
  // The display scan owns the port during active video; the FIFO head
  // owns it on a drain pop. Everything is held at zero while in reset.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_addr_c  = 19'd0;
    mem_wdata_c = 16'h0000;
    if (rst_n) begin
      if (bus.disp_ready) begin
        mem_addr_c = disp_addr;
      end else if (pop) begin
        mem_we_c    = 1'b1;
        mem_addr_c  = fifo_addr_q[rd_ptr_q];
        mem_wdata_c = fifo_data_q[rd_ptr_q];
      end
    end
  end

  // State, FIFO storage, pointers and registered write-ready.
  // Reset drops every queued write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_ptr_q   <= 2'd0;
      wr_ptr_q   <= 2'd0;
      level_q    <= 3'd0;
      wr_ready_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        fifo_addr_q[i] <= 19'd0;
        fifo_data_q[i] <= 16'h0000;
      end
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      wr_ready_q  <= wr_ready_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
    end
  end

  assign bus.wr_ready   = wr_ready_q;
  assign bus.fifo_level = level_q;

`else

  logic run_q;
  logic run_d;
  logic wr_fire;

  // Direct-write path: the writer may only transfer during blanking.
  always_comb begin
    run_d   = 1'b1;
    wr_fire = bus.wr_valid & run_q & ~bus.disp_ready & wr_addr_ok;
  end

  // RAM port mux.
  // The display scan owns the port during active video; an accepted
  // in-range write owns it during blanking. Everything is zero in reset.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_addr_c  = 19'd0;
    mem_wdata_c = 16'h0000;
    if (rst_n) begin
      if (bus.disp_ready) begin
        mem_addr_c = disp_addr;
      end else if (wr_fire) begin
        mem_we_c    = 1'b1;
        mem_addr_c  = bus.wr_addr;
        mem_wdata_c = bus.wr_data;
      end
    end
  end

  // Out-of-reset flag.
  // It keeps wr_ready low until the first clock edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= run_d;
    end
  end

  assign bus.wr_ready   = run_q & ~bus.disp_ready;
  assign bus.fifo_level = 3'd0;

`endif

endmodule

// File: tb/tb_vga_frame_arb.sv
// tb_vga_frame_arb
// Self-checking bench for vga_frame_arb.
//
// The bench contains:
//   - A behavioural pixel RAM (the environment).
//   - A reference model that tracks the queue of pending writes and its own
//     copy of the RAM contents.
//
// The bench follows VGA_ARB_WR_FIFO_EN the same way the design does.
module tb_vga_frame_arb;

  localparam int NPIX = 480000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  vga_frame_arb_if bus ();

  vga_frame_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Environment pixel RAM: synchronous write, one-cycle read latency.
  logic [15:0] ram     [NPIX];
  logic [15:0] ref_mem [NPIX];

  always @(posedge clk) begin
    if (int'(bus.mem_addr) < NPIX) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end else begin
      bus.mem_rdata <= 16'hDEAD;
    end
  end

  // Reference model state
  logic [18:0] q_addr [$];
  logic [15:0] q_data [$];
  bit          prev_disp;
  bit          ready_ok;
  logic [15:0] exp_pix;
  bit          pend_we;
  int          pend_addr;
  logic [15:0] pend_data;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    q_addr.delete();
    q_data.delete();
    prev_disp = 1'b0;
    ready_ok  = 1'b0;
    exp_pix   = 16'h0000;
    pend_we   = 1'b0;
  endtask

  // One cycle of the model: predict outputs from the current inputs, compare,
  // then advance the model to the state after the coming clock edge.
  task automatic modelCycle(input bit disp, input int c, input int r, input bit v,
                            input logic [18:0] a, input logic [15:0] d);
    int          daddr;
    int          exp_level;
    bit          exp_ready;
    bit          store;
    bit          exp_we;
    logic [18:0] exp_addr;
    logic [15:0] exp_wdata;
`ifdef VGA_ARB_WR_FIFO_EN
    bit          pop;
`endif
    if (pend_we) ref_mem[pend_addr] = pend_data;
    pend_we   = 1'b0;
    daddr     = r * 800 + c;
    exp_we    = 1'b0;
    exp_addr  = 19'd0;
    exp_wdata = 16'h0000;
`ifdef VGA_ARB_WR_FIFO_EN
    exp_level = q_addr.size();
    exp_ready = ready_ok && (exp_level < 4);
    // A drain pop only happens on a blanking cycle that follows another
    // blanking cycle, and only while something is queued.
    pop       = !disp && !prev_disp && (exp_level > 0);
    store     = v && exp_ready && (int'(a) < NPIX);
    if (pop) begin
      exp_we    = 1'b1;
      exp_addr  = q_addr[0];
      exp_wdata = q_data[0];
    end
`else
    exp_level = 0;
    exp_ready = ready_ok && !disp;
    store     = v && exp_ready && (int'(a) < NPIX);
    if (store) begin
      exp_we    = 1'b1;
      exp_addr  = a;
      exp_wdata = d;
    end
`endif
    checkOutput("wr_ready", bus.wr_ready, exp_ready);
    checkOutput("fifo_level", bus.fifo_level, exp_level);
    checkOutput("pix_valid", bus.pix_valid, prev_disp);
    checkOutput("pix_data", bus.pix_data, exp_pix);
    checkOutput("mem_we", bus.mem_we, exp_we);
    checkOutput("mem_wdata", bus.mem_wdata, exp_wdata);
    if (disp) checkOutput("mem_addr_disp", bus.mem_addr, 32'(daddr));
    else if (exp_we) checkOutput("mem_addr_wr", bus.mem_addr, exp_addr);
    if (exp_we) begin
      pend_we   = 1'b1;
      pend_addr = int'(exp_addr);
      pend_data = exp_wdata;
    end
`ifdef VGA_ARB_WR_FIFO_EN
    if (pop) begin
      void'(q_addr.pop_front());
      void'(q_data.pop_front());
    end
    if (store) begin
      q_addr.push_back(a);
      q_data.push_back(d);
    end
`endif
    exp_pix   = disp ? ref_mem[daddr] : 16'h0000;
    prev_disp = disp;
    ready_ok  = 1'b1;
  endtask

  task automatic applyStimulus(input bit disp, input int c, input int r, input bit v,
                               input logic [18:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    bus.disp_ready = disp;
    bus.col        = 11'(c);
    bus.row        = 11'(r);
    bus.wr_valid   = v;
    bus.wr_addr    = a;
    bus.wr_data    = d;
    @(negedge clk);
    modelCycle(disp, c, r, v, a, d);
  endtask

  task automatic resetDut(input int cycles);
    rst_n = 1'b0;
    resetModel();
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      bus.disp_ready = 1'b1;
      bus.col        = 11'($urandom_range(0, 799));
      bus.row        = 11'($urandom_range(0, 599));
      bus.wr_valid   = 1'b1;
      bus.wr_addr    = 19'($urandom_range(0, 479999));
      bus.wr_data    = 16'($urandom);
      @(negedge clk);
      checkOutput("rst_wr_ready", bus.wr_ready, 0);
      checkOutput("rst_fifo_level", bus.fifo_level, 0);
      checkOutput("rst_pix_valid", bus.pix_valid, 0);
      checkOutput("rst_pix_data", bus.pix_data, 0);
      checkOutput("rst_mem_we", bus.mem_we, 0);
      checkOutput("rst_mem_addr", bus.mem_addr, 0);
      checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
    end
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    bus.disp_ready = 1'b0;
    bus.wr_valid   = 1'b0;
    @(negedge clk);
    checkOutput("release_wr_ready", bus.wr_ready, 0);
    ready_ok = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit          disp_r;
    int          c;
    int          r;
    bit          v;
    logic [18:0] a;
    for (int i = 0; i < NPIX; i++) begin
      ram[i]     = 16'(i);
      ref_mem[i] = 16'(i);
    end
    bus.disp_ready = 1'b0;
    bus.col        = 11'd0;
    bus.row        = 11'd0;
    bus.wr_valid   = 1'b0;
    bus.wr_addr    = 19'd0;
    bus.wr_data    = 16'h0000;
    bus.mem_rdata  = 16'h0000;

    resetDut(3);

    $display("[TB] display read");
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 8; cc++) applyStimulus(1'b1, cc, rr, 1'b0, 19'd0, 16'h0);
    applyStimulus(1'b0, 0, 0, 1'b0, 19'd0, 16'h0);
    applyStimulus(1'b1, 5, 2, 1'b0, 19'd0, 16'h0);
    applyStimulus(1'b1, 6, 2, 1'b0, 19'd0, 16'h0);
    checkOutput("pix_at_5_2", bus.pix_data, 16'd1605);
    applyStimulus(1'b1, 799, 599, 1'b0, 19'd0, 16'h0);
    checkOutput("boundary_addr", bus.mem_addr, 19'd479999);
    repeat (2) applyStimulus(1'b0, 0, 0, 1'b0, 19'd0, 16'h0);

    $display("[TB] buffered writes during active video");
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, k, 0, 1'b1, 19'(8000 + k), 16'(16'hA000 + k));
    applyStimulus(1'b1, 4, 0, 1'b1, 19'd8004, 16'hA004);
`ifdef VGA_ARB_WR_FIFO_EN
    checkOutput("full_level", bus.fifo_level, 4);
`endif
    checkOutput("active_wr_ready", bus.wr_ready, 0);
    repeat (7) applyStimulus(1'b0, 0, 0, 1'b0, 19'd0, 16'h0);
    checkOutput("drained_level", bus.fifo_level, 0);

    $display("[TB] interrupted drain");
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, k, 1, 1'b1, 19'(8010 + k), 16'(16'hB000 + k));
    repeat (2) applyStimulus(1'b0, 0, 0, 1'b0, 19'd0, 16'h0);
    applyStimulus(1'b1, 3, 1, 1'b0, 19'd0, 16'h0);
`ifdef VGA_ARB_WR_FIFO_EN
    checkOutput("deferred_level", bus.fifo_level, 2);
`endif
    checkOutput("deferred_we", bus.mem_we, 0);
    applyStimulus(1'b1, 4, 1, 1'b0, 19'd0, 16'h0);
    repeat (5) applyStimulus(1'b0, 0, 0, 1'b0, 19'd0, 16'h0);

    $display("[TB] simultaneous push and pop");
    for (int k = 0; k < 2; k++) applyStimulus(1'b1, k, 2, 1'b1, 19'(8020 + k), 16'(16'hC000 + k));
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 0, 0, 1'b1, 19'(8022 + k), 16'(16'hC002 + k));
    repeat (6) applyStimulus(1'b0, 0, 0, 1'b0, 19'd0, 16'h0);

`ifndef VGA_ARB_WR_FIFO_EN
    $display("[TB] direct write during blanking");
    applyStimulus(1'b0, 0, 0, 1'b1, 19'd8030, 16'hD00D);
    checkOutput("direct_we", bus.mem_we, 1);
    checkOutput("direct_addr", bus.mem_addr, 19'd8030);
    checkOutput("direct_wdata", bus.mem_wdata, 16'hD00D);
`endif

    $display("[TB] out-of-range writes");
    applyStimulus(1'b0, 0, 0, 1'b1, 19'd480000, 16'hEEEE);
    applyStimulus(1'b0, 0, 0, 1'b1, 19'h7FFFF, 16'hEEEF);
    repeat (3) applyStimulus(1'b0, 0, 0, 1'b0, 19'd0, 16'h0);
    checkOutput("oor_level", bus.fifo_level, 0);

    $display("[TB] read back written row");
    for (int cc = 0; cc < 32; cc++) applyStimulus(1'b1, cc, 10, 1'b0, 19'd0, 16'h0);
    applyStimulus(1'b0, 0, 0, 1'b0, 19'd0, 16'h0);

    $display("[TB] reset during drain");
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, k, 3, 1'b1, 19'(8040 + k), 16'(16'hF000 + k));
    applyStimulus(1'b0, 0, 0, 1'b0, 19'd0, 16'h0);
    applyStimulus(1'b0, 0, 0, 1'b1, 19'd8043, 16'hF003);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_we", bus.mem_we, 0);
    checkOutput("rst_async_level", bus.fifo_level, 0);
    checkOutput("rst_async_ready", bus.wr_ready, 0);
    resetDut(2);
    for (int cc = 0; cc < 4; cc++) applyStimulus(1'b1, cc, 3, 1'b0, 19'd0, 16'h0);
    applyStimulus(1'b0, 0, 0, 1'b0, 19'd0, 16'h0);

    $display("[TB] randomized traffic");
    disp_r = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) disp_r = ~disp_r;
      c = $urandom_range(0, 15);
      r = $urandom_range(8, 13);
      if ($urandom_range(0, 49) == 0) begin
        c = 799;
        r = 599;
      end
      v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) a = 19'(480000 + $urandom_range(0, 44287));
      else a = 19'(6400 + $urandom_range(0, 4015));
      applyStimulus(disp_r, c, r, v, a, 16'($urandom));
    end
    repeat (8) applyStimulus(1'b0, 0, 0, 1'b0, 19'd0, 16'h0);
    for (int rr = 8; rr < 14; rr++)
      for (int cc = 0; cc < 16; cc++) applyStimulus(1'b1, cc, rr, 1'b0, 19'd0, 16'h0);
    applyStimulus(1'b0, 0, 0, 1'b0, 19'd0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_frame_arb.md
VGA_FRAME_ARB -- requirements
Module: vga_frame_arb

Interface
REQ-001 The block SHALL use reset rst_n, asynchronous, active-low, and clock clk.
REQ-002 The block SHALL expose these ports, clock and reset first; all flops SHALL be clocked on the rising edge of clk.
- clk  in  1  pixel clock, 40 MHz, 800x600@60
- rst_n  in  1  asynchronous active-low reset
- disp_ready  in  1  active-video flag from sync generator (registered there)
- col  in  11  display column 0..799, valid while disp_ready=1
- row  in  11  display row 0..599, valid while disp_ready=1
- wr_valid  in  1  writer request
- wr_ready  out  1  writer may transfer this cycle
- wr_addr  in  19  writer pixel address 0..479999
- wr_data  in  16  writer pixel, RGB565
- mem_addr  out  19  single-port pixel RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  16  RAM write data
- mem_rdata  in  16  RAM read data, one-cycle synchronous read latency
- pix_data  out  16  pixel to DAC
- pix_valid  out  1  pix_data valid
- fifo_level  out  3  write-buffer occupancy 0..4

Function
REQ-003 A write transfer SHALL occur on any cycle where wr_valid=1 and wr_ready=1.
REQ-004 The RAM SHALL be owned by the display on every cycle where disp_ready=1, with mem_we=0 and mem_addr=row*800+col.
REQ-005 The address product SHALL be computed at 19 bits; the maximum value, 479999, SHALL not overflow.
REQ-006 pix_valid SHALL equal disp_ready delayed by one cycle.
REQ-007 pix_data SHALL equal mem_rdata when pix_valid=1 and 16'h0000 otherwise.
REQ-008 Writes SHALL be buffered in a 4-entry FIFO, with wr_ready = (fifo_level<4).
- Writes are accepted during active video and during blanking.
REQ-009 The FSM SHALL have three states.
- IDLE: blanking, FIFO empty.
- DRAIN: blanking, FIFO non-empty.
- DISP: active video.
REQ-010 The FSM SHALL take these transitions, evaluated each cycle.
- Any state -> DISP when disp_ready=1.
- DISP -> DRAIN when disp_ready=0 and FIFO non-empty (after any push this cycle).
- DISP -> IDLE when disp_ready=0 and FIFO empty.
- DRAIN -> IDLE when the last entry pops with no simultaneous push.
- IDLE -> DRAIN on a push.
REQ-011 In DRAIN with disp_ready=0, exactly one entry SHALL pop per cycle.
- mem_we=1; mem_addr and mem_wdata come from the FIFO head.
- Entries drain in acceptance order.
REQ-012 In DRAIN, if disp_ready rises, the pop SHALL be suppressed that same cycle and the display takes the RAM; no entry is lost.
REQ-013 A simultaneous push and pop SHALL leave fifo_level unchanged and preserve order.
- When full, wr_ready=0, so no push occurs even on a pop cycle.
- wr_ready updates on the next cycle.
REQ-014 In IDLE and DISP, when not writing, mem_we SHALL be 0; mem_wdata SHALL be 0 whenever mem_we=0.
REQ-015 A write whose wr_addr is greater than 479999 SHALL be accepted and discarded: it is neither buffered nor written.

Reset
REQ-016 On rst_n=0, state SHALL be IDLE, the FIFO SHALL be empty, and these outputs SHALL be 0: fifo_level, pix_valid, pix_data, mem_we, mem_addr, mem_wdata.
REQ-017 wr_ready SHALL be 0 while rst_n=0 and SHALL be 1 from the first clock edge after release.
REQ-018 Reset asserted mid-drain SHALL discard all buffered writes; no partial write SHALL complete after assertion.

Configuration
REQ-019 When macro VGA_ARB_WR_FIFO_EN is defined, the FIFO behaviour of REQ-008 to REQ-013 SHALL apply.
REQ-020 When VGA_ARB_WR_FIFO_EN is undefined, the FIFO and the DRAIN state SHALL be removed, with this behaviour:
- wr_ready = ~disp_ready, outside reset.
- An accepted write drives mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data in the same cycle.
- fifo_level is tied to 0.
- Display behaviour is unchanged.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Display read: preload RAM[row*800+col] = row*800+col (low 16 bits); run one frame; expect pix_data at (col=5,row=2) = 16'd1605, one cycle after the address.
- Boundary: col=799, row=599 -> mem_addr=479999.
- Buffered writes: 4 writes during active video -> fifo_level=4, wr_ready=0, mem_we=0; at disp_ready fall, 4 consecutive mem_we pulses in order, then IDLE and fifo_level=0.
- Interrupted drain: 3 entries queued, disp_ready rises after the 1st pop -> 2nd pop deferred, fifo_level=2, drain resumes at next blanking.
- Simultaneous push/pop: push each cycle during DRAIN -> level constant, data order preserved.
- Reset mid-drain: assert rst_n=0 with fifo_level=3 -> mem_we=0 immediately, fifo_level=0.
- Macro undefined: write during blanking appears on mem_* the same cycle; wr_ready=0 throughout active video.
